// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and helper functions for the load/store unit.
// Build option: LSU_MISALIGN_TRAP_EN (see lsu_mem_ctrl.sv).
package lsu_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // RV32 size/sign codes (stores reuse the B/H/W encodings)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Four byte lanes, lane 0 holds the least significant byte of the word
  typedef logic [0:3][7:0] byte_lanes_t;

  // Half on an odd offset or word on a non-zero offset crosses its natural boundary
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Loads allow 0,1,2,4,5; stores allow 0,1,2
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    logic ill;
    if (we) begin
      ill = (funct3 > 3'd2);
    end else begin
      ill = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
    end
    return ill;
  endfunction

  // Force the lane offset down to the natural boundary of the access size
  function automatic logic [1:0] align_offset(input logic [2:0] funct3, input logic [1:0] off);
    logic [1:0] o;
    o = off;
    case (funct3[1:0])
      2'b01:   o = {off[1], 1'b0};
      2'b10:   o = 2'b00;
      default: o = off;
    endcase
    return o;
  endfunction

  // Split a 32-bit word into byte lanes
  function automatic byte_lanes_t word_to_lanes(input logic [31:0] w);
    byte_lanes_t l;
    l[0] = w[7:0];
    l[1] = w[15:8];
    l[2] = w[23:16];
    l[3] = w[31:24];
    return l;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: load extract/extend and store merge.
// The offset is expected to be already aligned (or trapped) by the caller.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [0:3][7:0] rdata,
  input  logic [31:0]     wdata,
  output logic [31:0]     ld_data,
  output logic [0:3][7:0] st_lanes
);

  logic [1:0] off_hi_s;
  logic [7:0] lo_byte_s;
  logic [7:0] hi_byte_s;

  assign off_hi_s  = off + 2'd1;
  assign lo_byte_s = rdata[off];
  assign hi_byte_s = rdata[off_hi_s];

  // Load path: select the addressed lanes and sign/zero extend from the top used byte
  always_comb begin
    ld_data = 32'h0000_0000;
    case (funct3)
      F3_B:    ld_data = {{24{lo_byte_s[7]}}, lo_byte_s};
      F3_BU:   ld_data = {24'h00_0000, lo_byte_s};
      F3_H:    ld_data = {{16{hi_byte_s[7]}}, hi_byte_s, lo_byte_s};
      F3_HU:   ld_data = {16'h0000, hi_byte_s, lo_byte_s};
      F3_W:    ld_data = {rdata[3], rdata[2], rdata[1], rdata[0]};
      default: ld_data = 32'h0000_0000;
    endcase
  end

  // Store path: overlay the store bytes on the word read back, keeping untouched lanes
  always_comb begin
    st_lanes = rdata;
    case (funct3)
      F3_B: begin
        st_lanes[off] = wdata[7:0];
      end
      F3_H: begin
        st_lanes[off]      = wdata[7:0];
        st_lanes[off_hi_s] = wdata[15:8];
      end
      F3_W: begin
        st_lanes = word_to_lanes(wdata);
      end
      default: begin
        st_lanes = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit controller: one request at a time, memory handshake,
// read-modify-write for byte/half stores, extended load writeback.
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned accesses
// with rsp_fault; otherwise misaligned offsets are aligned down and
// rsp_fault stays 0.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              rsp_valid,
  output logic              rsp_wb,
  output logic [XLEN-1:0]   rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_fault,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [0:3][7:0]   mem_wdata,
  input  logic [0:3][7:0]   mem_rdata,
  input  logic              mem_ack
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic FAULT_ON_TRAP = 1'b1;
`else
  localparam logic FAULT_ON_TRAP = 1'b0;
`endif

  lsu_state_e        state_r;
  logic              we_r;
  logic [2:0]        f3_r;
  logic [1:0]        off_r;
  logic [31:0]       wdata_r;
  logic [4:0]        rd_r;

  logic              req_ready_r;
  logic              busy_r;
  logic              rsp_valid_r;
  logic              rsp_wb_r;
  logic [XLEN-1:0]   rsp_data_r;
  logic [4:0]        rsp_rd_r;
  logic              rsp_fault_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  byte_lanes_t       mem_wdata_r;

  logic              illegal_s;
  logic              trap_s;
  logic [1:0]        off_eff_s;
  logic [31:0]       ld_data_s;
  byte_lanes_t       st_lanes_s;

  // Classify the incoming request: trapped (no memory cycle) and effective lane offset
  always_comb begin
    illegal_s = is_illegal(req_we, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    off_eff_s = req_addr[1:0];
    trap_s    = illegal_s | is_misaligned(req_funct3, req_addr[1:0]);
`else
    off_eff_s = align_offset(req_funct3, req_addr[1:0]);
    trap_s    = illegal_s;
`endif
  end

  lsu_lane_align u_lane_align (
    .funct3   (f3_r),
    .off      (off_r),
    .rdata    (mem_rdata),
    .wdata    (wdata_r),
    .ld_data  (ld_data_s),
    .st_lanes (st_lanes_s)
  );

  // Controller FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_r     <= ST_IDLE;
      we_r        <= 1'b0;
      f3_r        <= 3'b000;
      off_r       <= 2'b00;
      wdata_r     <= 32'h0000_0000;
      rd_r        <= 5'd0;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_wb_r    <= 1'b0;
      rsp_data_r  <= {XLEN{1'b0}};
      rsp_rd_r    <= 5'd0;
      rsp_fault_r <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rsp_valid_r <= 1'b0;
          rsp_wb_r    <= 1'b0;
          rsp_fault_r <= 1'b0;
          if (req_valid && req_ready_r) begin
            we_r        <= req_we;
            f3_r        <= req_funct3;
            off_r       <= off_eff_s;
            wdata_r     <= req_wdata[31:0];
            rd_r        <= req_rd;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            mem_addr_r  <= {req_addr[ADDR_W-1:2], 2'b00};
            if (trap_s) begin
              // Rejected without touching memory
              state_r     <= ST_RESP;
              rsp_valid_r <= 1'b1;
              rsp_wb_r    <= 1'b0;
              rsp_data_r  <= {XLEN{1'b0}};
              rsp_rd_r    <= req_rd;
              rsp_fault_r <= FAULT_ON_TRAP;
            end else if (!req_we) begin
              state_r   <= ST_RD;
              mem_req_r <= 1'b1;
              mem_we_r  <= 1'b0;
            end else if (req_funct3 == F3_W) begin
              // Full word store needs no read-back
              state_r     <= ST_WR;
              mem_req_r   <= 1'b1;
              mem_we_r    <= 1'b1;
              mem_wdata_r <= word_to_lanes(req_wdata[31:0]);
            end else begin
              // Byte/half store: read the word first, merge, then write
              state_r   <= ST_RD;
              mem_req_r <= 1'b1;
              mem_we_r  <= 1'b0;
            end
          end else begin
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end

        ST_RD: begin
          if (mem_ack) begin
            if (we_r) begin
              // Keep the request up and turn it into the merged write
              state_r     <= ST_WR;
              mem_we_r    <= 1'b1;
              mem_wdata_r <= st_lanes_s;
            end else begin
              state_r     <= ST_RESP;
              mem_req_r   <= 1'b0;
              rsp_valid_r <= 1'b1;
              rsp_wb_r    <= 1'b1;
              rsp_data_r  <= ld_data_s;
              rsp_rd_r    <= rd_r;
              rsp_fault_r <= 1'b0;
            end
          end else begin
            state_r <= ST_RD;
          end
        end

        ST_WR: begin
          if (mem_ack) begin
            state_r     <= ST_RESP;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_wb_r    <= 1'b0;
            rsp_data_r  <= {XLEN{1'b0}};
            rsp_rd_r    <= rd_r;
            rsp_fault_r <= 1'b0;
          end else begin
            state_r <= ST_WR;
          end
        end

        ST_RESP: begin
          // Single response cycle, then ready again
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
          rsp_wb_r    <= 1'b0;
          rsp_fault_r <= 1'b0;
          rsp_data_r  <= {XLEN{1'b0}};
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end

        default: begin
          state_r     <= ST_IDLE;
          mem_req_r   <= 1'b0;
          mem_we_r    <= 1'b0;
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_wb    = rsp_wb_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_rd    = rsp_rd_r;
  assign rsp_fault = rsp_fault_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl; expectations follow LSU_MISALIGN_TRAP_EN.
module tb_lsu_mem_ctrl;

  logic              clk = 1'b0;
  logic              rst_b;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;
  logic              rsp_valid;
  logic              rsp_wb;
  logic [31:0]       rsp_data;
  logic [4:0]        rsp_rd;
  logic              rsp_fault;
  logic              busy;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [0:3][7:0]   mem_wdata;
  logic [0:3][7:0]   mem_rdata;
  logic              mem_ack;

  int checks = 0;
  int errors = 0;

  // observations of the last transaction
  int          o_lat, o_reads, o_writes, o_pulses, o_busy;
  logic [31:0] o_data, o_wr_word, o_wr_addr, o_rd_addr;
  logic        o_wb, o_fault, o_acc, o_ready_after, o_stable;
  logic [4:0]  o_rd;

  lsu_mem_ctrl #(.ADDR_W(32), .XLEN(32)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_wb(rsp_wb), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .rsp_fault(rsp_fault), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lanes_to_word(input logic [0:3][7:0] l);
    return {l[3], l[2], l[1], l[0]};
  endfunction

  // Issue one request and act as memory that acks after ack_dly waiting cycles
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input int ack_dly, input logic [31:0] mem_word);
    int w;
    int tail;
    logic prev_req, prev_ack, prev_we;
    logic [31:0] prev_addr;
    o_lat = -1; o_reads = 0; o_writes = 0; o_pulses = 0; o_busy = 0;
    o_data = 32'h0; o_wr_word = 32'h0; o_wr_addr = 32'h0; o_rd_addr = 32'h0;
    o_wb = 1'b0; o_fault = 1'b0; o_ready_after = 1'b0; o_stable = 1'b1; o_rd = 5'd0;
    mem_rdata[0] = mem_word[7:0];
    mem_rdata[1] = mem_word[15:8];
    mem_rdata[2] = mem_word[23:16];
    mem_rdata[3] = mem_word[31:24];
    mem_ack = 1'b0;
    @(negedge clk);
    o_acc      = req_ready;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    w = 0; tail = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_we = 1'b0; prev_addr = 32'h0;
    for (int cyc = 1; cyc <= 40 && tail < 3; cyc++) begin
      @(negedge clk);
      if (mem_req) begin
        if (prev_req && !prev_ack && (mem_addr !== prev_addr || mem_we !== prev_we))
          o_stable = 1'b0;
        mem_ack = (w >= ack_dly);
        if (mem_ack) begin
          if (mem_we) begin
            o_writes++;
            o_wr_word = lanes_to_word(mem_wdata);
            o_wr_addr = mem_addr;
          end else begin
            o_reads++;
            o_rd_addr = mem_addr;
          end
          w = 0;
        end else begin
          w++;
        end
      end else begin
        mem_ack = 1'b0;
      end
      prev_req = mem_req; prev_ack = mem_ack; prev_we = mem_we; prev_addr = mem_addr;
      if (rsp_valid) begin
        o_pulses++;
        if (o_lat < 0) begin
          o_lat = cyc; o_data = rsp_data; o_wb = rsp_wb; o_fault = rsp_fault; o_rd = rsp_rd;
        end
      end
      if (o_lat < 0 || o_lat == cyc) begin
        if (busy && !req_ready) o_busy++;
      end
      if (o_lat >= 0 && cyc == o_lat + 1) o_ready_after = req_ready;
      if (o_lat >= 0) tail++;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, busy, mem_req, mem_we, rsp_valid, rsp_wb, rsp_fault} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 1000000", {req_ready, busy, mem_req, mem_we, rsp_valid, rsp_wb, rsp_fault});
    end
    checks++;
    if (mem_addr !== 32'h0 || lanes_to_word(mem_wdata) !== 32'h0 || rsp_data !== 32'h0 || rsp_rd !== 5'd0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h rd=%0d expected all 0",
               mem_addr, lanes_to_word(mem_wdata), rsp_data, rsp_rd);
    end
    rst_b = 1'b0;
  endtask

  task automatic test_lw();
    run_req(1'b0, 3'd2, 32'h100, 32'h0, 5'd7, 0, 32'h44332211);
    checks++;
    if (o_acc !== 1'b1) begin errors++; $display("FAIL lw_accept: got %b expected 1", o_acc); end
    checks++;
    if (o_lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d expected 2", o_lat); end
    checks++;
    if (o_data !== 32'h44332211) begin errors++; $display("FAIL lw_data: got %h expected 44332211", o_data); end
    checks++;
    if ({o_wb, o_fault} !== 2'b10 || o_rd !== 5'd7) begin
      errors++; $display("FAIL lw_wb: wb=%b fault=%b rd=%0d expected 1 0 7", o_wb, o_fault, o_rd);
    end
    checks++;
    if (o_reads !== 1 || o_writes !== 0 || o_rd_addr !== 32'h100) begin
      errors++; $display("FAIL lw_mem: reads=%0d writes=%0d addr=%h expected 1 0 100", o_reads, o_writes, o_rd_addr);
    end
  endtask

  task automatic test_load_extend();
    run_req(1'b0, 3'd0, 32'h103, 32'h0, 5'd3, 0, 32'h80332211);
    checks++;
    if (o_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_neg: got %h expected ffffff80", o_data); end
    run_req(1'b0, 3'd4, 32'h103, 32'h0, 5'd3, 0, 32'h80332211);
    checks++;
    if (o_data !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h expected 00000080", o_data); end
    run_req(1'b0, 3'd0, 32'h101, 32'h0, 5'd4, 0, 32'h44337F11);
    checks++;
    if (o_data !== 32'h0000007F) begin errors++; $display("FAIL lb_pos: got %h expected 0000007f", o_data); end
    run_req(1'b0, 3'd1, 32'h102, 32'h0, 5'd5, 0, 32'h9ABC2211);
    checks++;
    if (o_data !== 32'hFFFF9ABC) begin errors++; $display("FAIL lh_neg: got %h expected ffff9abc", o_data); end
    run_req(1'b0, 3'd5, 32'h102, 32'h0, 5'd5, 0, 32'h9ABC2211);
    checks++;
    if (o_data !== 32'h00009ABC) begin errors++; $display("FAIL lhu: got %h expected 00009abc", o_data); end
  endtask

  task automatic test_store();
    run_req(1'b1, 3'd0, 32'h102, 32'hDEADBEAB, 5'd9, 0, 32'h44332211);
    checks++;
    if (o_reads !== 1 || o_writes !== 1 || o_wr_word !== 32'h44AB2211 || o_wr_addr !== 32'h100) begin
      errors++; $display("FAIL sb_rmw: reads=%0d writes=%0d word=%h addr=%h expected 1 1 44ab2211 100",
                         o_reads, o_writes, o_wr_word, o_wr_addr);
    end
    checks++;
    if (o_lat !== 3 || o_wb !== 1'b0 || o_data !== 32'h0) begin
      errors++; $display("FAIL sb_rsp: lat=%0d wb=%b data=%h expected 3 0 0", o_lat, o_wb, o_data);
    end
    run_req(1'b1, 3'd1, 32'h106, 32'h00001234, 5'd9, 0, 32'h44332211);
    checks++;
    if (o_wr_word !== 32'h12342211 || o_wr_addr !== 32'h104) begin
      errors++; $display("FAIL sh_rmw: word=%h addr=%h expected 12342211 104", o_wr_word, o_wr_addr);
    end
    run_req(1'b1, 3'd2, 32'h108, 32'hCAFEF00D, 5'd9, 0, 32'h44332211);
    checks++;
    if (o_reads !== 0 || o_writes !== 1 || o_wr_word !== 32'hCAFEF00D || o_lat !== 2) begin
      errors++; $display("FAIL sw: reads=%0d writes=%0d word=%h lat=%0d expected 0 1 cafef00d 2",
                         o_reads, o_writes, o_wr_word, o_lat);
    end
  endtask

  task automatic test_wait_states();
    run_req(1'b0, 3'd2, 32'h200, 32'h0, 5'd12, 5, 32'h01020304);
    checks++;
    if (o_lat !== 7 || o_data !== 32'h01020304) begin
      errors++; $display("FAIL wait_lat: lat=%0d data=%h expected 7 01020304", o_lat, o_data);
    end
    checks++;
    if (o_stable !== 1'b1) begin errors++; $display("FAIL wait_stable: got %b expected 1", o_stable); end
    checks++;
    if (o_busy !== 7 || o_pulses !== 1) begin
      errors++; $display("FAIL wait_busy: busy_cycles=%0d pulses=%0d expected 7 1", o_busy, o_pulses);
    end
  endtask

  task automatic test_misalign();
    run_req(1'b0, 3'd1, 32'h101, 32'h0, 5'd6, 0, 32'h44338211);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if (o_reads !== 0 || o_writes !== 0 || o_fault !== 1'b1 || o_wb !== 1'b0 || o_data !== 32'h0 || o_lat !== 1) begin
      errors++; $display("FAIL lh_mis: reads=%0d writes=%0d fault=%b wb=%b data=%h lat=%0d expected 0 0 1 0 0 1",
                         o_reads, o_writes, o_fault, o_wb, o_data, o_lat);
    end
`else
    checks++;
    if (o_rd_addr !== 32'h100 || o_data !== 32'hFFFF8211 || o_fault !== 1'b0 || o_lat !== 2) begin
      errors++; $display("FAIL lh_mis: addr=%h data=%h fault=%b lat=%0d expected 100 ffff8211 0 2",
                         o_rd_addr, o_data, o_fault, o_lat);
    end
`endif
    run_req(1'b1, 3'd1, 32'h103, 32'h00005566, 5'd6, 0, 32'h44332211);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if (o_writes !== 0 || o_reads !== 0 || o_fault !== 1'b1) begin
      errors++; $display("FAIL sh_mis: writes=%0d reads=%0d fault=%b expected 0 0 1", o_writes, o_reads, o_fault);
    end
`else
    checks++;
    if (o_wr_word !== 32'h55662211 || o_wr_addr !== 32'h100 || o_lat !== 3) begin
      errors++; $display("FAIL sh_mis: word=%h addr=%h lat=%0d expected 55662211 100 3", o_wr_word, o_wr_addr, o_lat);
    end
`endif
  endtask

  task automatic test_illegal();
    logic exp_fault;
`ifdef LSU_MISALIGN_TRAP_EN
    exp_fault = 1'b1;
`else
    exp_fault = 1'b0;
`endif
    run_req(1'b0, 3'd3, 32'h100, 32'h0, 5'd8, 0, 32'h44332211);
    checks++;
    if (o_reads !== 0 || o_writes !== 0 || o_lat !== 1 || o_wb !== 1'b0 || o_fault !== exp_fault || o_data !== 32'h0) begin
      errors++; $display("FAIL ill_load: reads=%0d writes=%0d lat=%0d wb=%b fault=%b data=%h expected 0 0 1 0 %b 0",
                         o_reads, o_writes, o_lat, o_wb, o_fault, o_data, exp_fault);
    end
    run_req(1'b1, 3'd4, 32'h100, 32'h12345678, 5'd8, 0, 32'h44332211);
    checks++;
    if (o_reads !== 0 || o_writes !== 0 || o_lat !== 1 || o_fault !== exp_fault) begin
      errors++; $display("FAIL ill_store: reads=%0d writes=%0d lat=%0d fault=%b expected 0 0 1 %b",
                         o_reads, o_writes, o_lat, o_fault, exp_fault);
    end
  endtask

  task automatic test_back_to_back();
    run_req(1'b0, 3'd2, 32'h300, 32'h0, 5'd1, 0, 32'hA5A5_0001);
    checks++;
    if (o_ready_after !== 1'b1 || o_pulses !== 1) begin
      errors++; $display("FAIL b2b_first: ready_after=%b pulses=%0d expected 1 1", o_ready_after, o_pulses);
    end
    run_req(1'b0, 3'd2, 32'h304, 32'h0, 5'd2, 0, 32'h5A5A_0002);
    checks++;
    if (o_acc !== 1'b1 || o_data !== 32'h5A5A0002 || o_rd !== 5'd2) begin
      errors++; $display("FAIL b2b_second: acc=%b data=%h rd=%0d expected 1 5a5a0002 2", o_acc, o_data, o_rd);
    end
  endtask

  task automatic test_reset_mid_op();
    mem_ack = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h400;
    req_wdata = 32'h0BADF00D; req_rd = 5'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h400) begin
      errors++; $display("FAIL rst_wr_state: req=%b we=%b addr=%h expected 1 1 400", mem_req, mem_we, mem_addr);
    end
    @(negedge clk);
    rst_b = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req, req_ready, rsp_valid, busy} !== 4'b0100) begin
      errors++; $display("FAIL rst_mid: req,ready,rsp,busy=%b expected 0100", {mem_req, req_ready, rsp_valid, busy});
    end
    rst_b = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_after: rsp=%b req=%b ready=%b expected 0 0 1", rsp_valid, mem_req, req_ready);
    end
  endtask

  initial begin
    rst_b = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    mem_rdata = 32'h0; mem_ack = 1'b0;
    test_reset();
    test_lw();
    test_load_extend();
    test_store();
    test_wait_states();
    test_misalign();
    test_illegal();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
